// File: rtl/fft_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sched
// Purpose  : Frame scheduler for the FFT magnitude RAM: sequences
//            IDLE -> CAPTURE -> FLUSH -> READ and arbitrates the RAM read port
//            between the peak detector (port 0) and the UART dump (port 1).
// Options  : FFT_SCHED_WATCHDOG_EN adds a 16-bit CAPTURE timeout.
// Revision : 1.0  initial release
// ============================================================================
module fft_frame_sched (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  input  logic       s_frame_start,
  output logic       m_capture_en,
  input  logic       s_magni_valid,
  input  logic [9:0] s_magni_addr,
  input  logic       s_req0,
  input  logic       s_req1,
  input  logic [8:0] s_addr0,
  input  logic [8:0] s_addr1,
  output logic       m_gnt0,
  output logic       m_gnt1,
  output logic [8:0] m_ram_addr,
  input  logic       s_read_done,
  output logic       m_busy,
  output logic [1:0] m_state,
  output logic [7:0] m_frame_cnt,
  output logic       m_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READ    = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [9:0] C_LAST_ADDR = 10'd511;
  localparam logic [9:0] C_FULL_CNT  = 10'd512;
  localparam logic [9:0] C_CNT_MAX   = 10'h3FF;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_capture_en;
  logic       r_err;
  logic       r_flush_cnt;
  logic [9:0] r_wr_cnt;
  logic [7:0] r_frame_cnt;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_rr_pri;
  logic [8:0] r_addr_hold;

  logic       w_last_wr;
  logic       w_wr_lower;
  logic [9:0] w_wr_cnt_nxt;
  logic       w_short;
  logic       w_timeout;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_gnt_any;
  logic       w_new_gnt0;
  logic       w_new_gnt1;
  logic [8:0] w_ram_addr;

  assign w_last_wr    = s_magni_valid && (s_magni_addr == C_LAST_ADDR);
  assign w_wr_lower   = s_magni_valid && !s_magni_addr[9];
  // Saturating so duplicate-address bursts cannot wrap back below 512.
  assign w_wr_cnt_nxt = (w_wr_lower && (r_wr_cnt != C_CNT_MAX)) ? r_wr_cnt + 10'd1
                                                                 : r_wr_cnt;
  assign w_short      = (w_wr_cnt_nxt < C_FULL_CNT);

`ifdef FFT_SCHED_WATCHDOG_EN
  logic [15:0] r_wd_cnt;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_wd_cnt <= '0;
    end else if (r_state != ST_CAPTURE) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  // Fires on the 65535th CAPTURE cycle; a genuine last write wins a tie.
  assign w_timeout = (r_state == ST_CAPTURE) && (r_wd_cnt == 16'hFFFE) && !w_last_wr;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (s_frame_start) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_last_wr)      w_state_nxt = ST_FLUSH;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        if (r_flush_cnt) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        if (s_read_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_capture_en <= 1'b0;
      r_err        <= 1'b0;
      r_flush_cnt  <= 1'b0;
      r_wr_cnt     <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_capture_en <= (w_state_nxt == ST_CAPTURE);
      r_err        <= ((r_state == ST_CAPTURE) && w_last_wr && w_short) || w_timeout;
      r_flush_cnt  <= (r_state == ST_FLUSH) ? !r_flush_cnt : 1'b0;
      r_wr_cnt     <= (r_state == ST_CAPTURE) ? w_wr_cnt_nxt : '0;
      if ((r_state == ST_READ) && s_read_done) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // Registered grant is masked by its live request and by read_done, so a
  // grant vanishes in the very cycle the requester lets go.
  assign w_gnt0    = r_gnt0 && s_req0 && !s_read_done;
  assign w_gnt1    = r_gnt1 && s_req1 && !s_read_done;
  assign w_gnt_any = w_gnt0 || w_gnt1;

  always_comb begin
    w_new_gnt0 = 1'b0;
    w_new_gnt1 = 1'b0;
    if ((r_state == ST_READ) && !s_read_done) begin
      if (w_gnt_any) begin
        w_new_gnt0 = w_gnt0;
        w_new_gnt1 = w_gnt1;
      end else if (s_req0 && s_req1) begin
        w_new_gnt0 = !r_rr_pri;
        w_new_gnt1 = r_rr_pri;
      end else begin
        w_new_gnt0 = s_req0;
        w_new_gnt1 = s_req1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rr_pri    <= 1'b0;
      r_addr_hold <= '0;
    end else begin
      r_gnt0      <= w_new_gnt0;
      r_gnt1      <= w_new_gnt1;
      r_addr_hold <= w_ram_addr;
      if (!w_gnt_any && (w_new_gnt0 || w_new_gnt1)) begin
        r_rr_pri <= w_new_gnt0;
      end
    end
  end

  assign w_ram_addr   = w_gnt0 ? s_addr0 : (w_gnt1 ? s_addr1 : r_addr_hold);

  assign m_capture_en = r_capture_en;
  assign m_gnt0       = w_gnt0;
  assign m_gnt1       = w_gnt1;
  assign m_ram_addr   = w_ram_addr;
  assign m_busy       = (r_state != ST_IDLE);
  assign m_state      = r_state;
  assign m_frame_cnt  = r_frame_cnt;
  assign m_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_sched
// Purpose  : Self-checking bench for fft_frame_sched using a rule-level model
//            of frame phases, write counting and round-robin read arbitration.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_frame_sched;

  logic       sys_clk = 1'b0;
  logic       sys_rstn;
  logic       s_frame_start;
  logic       m_capture_en;
  logic       s_magni_valid;
  logic [9:0] s_magni_addr;
  logic       s_req0;
  logic       s_req1;
  logic [8:0] s_addr0;
  logic [8:0] s_addr1;
  logic       m_gnt0;
  logic       m_gnt1;
  logic [8:0] m_ram_addr;
  logic       s_read_done;
  logic       m_busy;
  logic [1:0] m_state;
  logic [7:0] m_frame_cnt;
  logic       m_err;

  int         n_checks = 0;
  int         n_errors = 0;

  int         own;
  int         pri;
  logic [8:0] hold;
  logic [7:0] exp_frames;

  always #10 sys_clk = ~sys_clk;

  fft_frame_sched dut (
    .sys_clk       (sys_clk),
    .sys_rstn      (sys_rstn),
    .s_frame_start (s_frame_start),
    .m_capture_en  (m_capture_en),
    .s_magni_valid (s_magni_valid),
    .s_magni_addr  (s_magni_addr),
    .s_req0        (s_req0),
    .s_req1        (s_req1),
    .s_addr0       (s_addr0),
    .s_addr1       (s_addr1),
    .m_gnt0        (m_gnt0),
    .m_gnt1        (m_gnt1),
    .m_ram_addr    (m_ram_addr),
    .s_read_done   (s_read_done),
    .m_busy        (m_busy),
    .m_state       (m_state),
    .m_frame_cnt   (m_frame_cnt),
    .m_err         (m_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One cycle outside arbitration: the phase expectation comes from the caller.
  task automatic ctl_cycle(input logic fs, input logic vld, input logic [9:0] addr,
                           input int est, input logic ecap, input logic eerr);
    s_frame_start = fs;
    s_magni_valid = vld;
    s_magni_addr  = addr;
    s_addr0       = 9'($urandom);
    s_addr1       = 9'($urandom);
    if (est == 2) begin
      s_req0      = 1'b0;
      s_req1      = 1'b0;
      s_read_done = 1'b0;
    end else begin
      s_req0      = 1'($urandom_range(0, 1));
      s_req1      = 1'($urandom_range(0, 1));
      s_read_done = ($urandom_range(0, 3) == 0);
    end
    #5;
    check("state",      32'(m_state),      32'(est));
    check("capture_en", 32'(m_capture_en), 32'(ecap));
    check("busy",       32'(m_busy),       32'(est != 0));
    check("err",        32'(m_err),        32'(eerr));
    check("gnt0_idle",  32'(m_gnt0),       32'd0);
    check("gnt1_idle",  32'(m_gnt1),       32'd0);
    check("addr_hold",  32'(m_ram_addr),   32'(hold));
    check("frame_cnt",  32'(m_frame_cnt),  32'(exp_frames));
    tick();
  endtask

  // One READ cycle predicted from the arbitration rules.
  task automatic read_cycle(input logic r0, input logic r1, input logic [8:0] a0,
                            input logic [8:0] a1, input logic done, input logic fs);
    logic       eg0;
    logic       eg1;
    logic [8:0] ea;
    s_frame_start = fs;
    s_magni_valid = 1'b0;
    s_magni_addr  = '0;
    s_req0        = r0;
    s_req1        = r1;
    s_addr0       = a0;
    s_addr1       = a1;
    s_read_done   = done;
    eg0 = (own == 0) && r0 && !done;
    eg1 = (own == 1) && r1 && !done;
    ea  = eg0 ? a0 : (eg1 ? a1 : hold);
    #5;
    check("rd_state", 32'(m_state),    32'd2);
    check("rd_gnt0",  32'(m_gnt0),     32'(eg0));
    check("rd_gnt1",  32'(m_gnt1),     32'(eg1));
    check("rd_addr",  32'(m_ram_addr), 32'(ea));
    hold = ea;
    if (done) begin
      own = -1;
    end else if (!(eg0 || eg1)) begin
      if (r0 && r1) begin
        own = pri;
        pri = 1 - pri;
      end else if (r0) begin
        own = 0;
        pri = 1;
      end else if (r1) begin
        own = 1;
        pri = 0;
      end else begin
        own = -1;
      end
    end
    tick();
    if (done) exp_frames = exp_frames + 8'd1;
  endtask

  task automatic flush_phase(input int n_low);
    ctl_cycle(1'b0, 1'b0, 10'd0, 3, 1'b0, (n_low < 512));
    ctl_cycle(1'b0, 1'b0, 10'd0, 3, 1'b0, 1'b0);
  endtask

  task automatic quick_frame();
    ctl_cycle(1'b1, 1'b0, 10'd0, 0, 1'b0, 1'b0);
    ctl_cycle(1'b0, 1'b1, 10'd511, 1, 1'b1, 1'b0);
    flush_phase(1);
    read_cycle(1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b0);
  endtask

  task automatic model_reset();
    own        = -1;
    pri        = 0;
    hold       = '0;
    exp_frames = '0;
  endtask

  initial begin
    logic r0;
    logic r1;
    int   n_low;
    int   kind;

    sys_rstn      = 1'b0;
    s_frame_start = 1'b0;
    s_magni_valid = 1'b0;
    s_magni_addr  = '0;
    s_req0        = 1'b0;
    s_req1        = 1'b0;
    s_addr0       = '0;
    s_addr1       = '0;
    s_read_done   = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_state",  32'(m_state),      32'd0);
    check("rst_busy",   32'(m_busy),       32'd0);
    check("rst_cap",    32'(m_capture_en), 32'd0);
    check("rst_gnt",    32'({m_gnt1, m_gnt0}), 32'd0);
    check("rst_frames", 32'(m_frame_cnt),  32'd0);
    check("rst_err",    32'(m_err),        32'd0);
    check("rst_addr",   32'(m_ram_addr),   32'd0);
    sys_rstn = 1'b1;
    ctl_cycle(1'b0, 1'b0, 10'd0, 0, 1'b0, 1'b0);

    // Full capture: addresses 0..1023 stream continuously; only 0..511 matter.
    ctl_cycle(1'b1, 1'b0, 10'd0, 0, 1'b0, 1'b0);
    for (int a = 0; a < 512; a++) begin
      ctl_cycle(($urandom_range(0, 15) == 0), 1'b1, 10'(a), 1, 1'b1, 1'b0);
    end
    for (int k = 0; k < 512; k++) begin
      ctl_cycle(1'b0, 1'b1, 10'(512 + k), (k < 2) ? 3 : 2, 1'b0, 1'b0);
    end

    // Directed arbitration: tie to 0, release, tie to 1, address pass-through.
    read_cycle(1'b1, 1'b1, 9'h011, 9'h022, 1'b0, 1'b0);
    check("tie_a_gnt0", 32'(m_gnt0), 32'd1);
    check("tie_a_gnt1", 32'(m_gnt1), 32'd0);
    read_cycle(1'b1, 1'b1, 9'h033, 9'h044, 1'b0, 1'b0);
    read_cycle(1'b0, 1'b0, 9'h055, 9'h066, 1'b0, 1'b0);
    check("drop_gnt0", 32'(m_gnt0), 32'd0);
    read_cycle(1'b1, 1'b1, 9'h077, 9'h088, 1'b0, 1'b1);
    check("tie_b_gnt1", 32'(m_gnt1), 32'd1);
    check("tie_b_gnt0", 32'(m_gnt0), 32'd0);
    read_cycle(1'b1, 1'b1, 9'h099, 9'h1A5, 1'b0, 1'b0);
    check("addr_1a5", 32'(m_ram_addr), 32'h1A5);

    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      read_cycle(r0, r1, 9'($urandom), 9'($urandom), 1'b0, 1'b0);
    end
    read_cycle(1'b1, 1'b1, 9'($urandom), 9'($urandom), 1'b1, 1'b1);
    check("done_state", 32'(m_state),     32'd0);
    check("done_gnts",  32'({m_gnt1, m_gnt0}), 32'd0);
    check("frame_one",  32'(m_frame_cnt), 32'd1);
    ctl_cycle(1'b0, 1'b0, 10'd0, 0, 1'b0, 1'b0);

    // Short capture: 300 lower-half writes mixed with upper writes and gaps.
    ctl_cycle(1'b1, 1'b0, 10'd0, 0, 1'b0, 1'b0);
    n_low = 0;
    while (n_low < 300) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        ctl_cycle(1'b0, 1'b0, 10'd0, 1, 1'b1, 1'b0);
      end else if (kind == 1) begin
        ctl_cycle(1'b0, 1'b1, 10'(512 + $urandom_range(0, 511)), 1, 1'b1, 1'b0);
      end else begin
        ctl_cycle(1'b0, 1'b1, 10'($urandom_range(0, 510)), 1, 1'b1, 1'b0);
        n_low++;
      end
    end
    ctl_cycle(1'b0, 1'b1, 10'd511, 1, 1'b1, 1'b0);
    n_low++;
    flush_phase(n_low);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) r0 = ~r0;
      if ($urandom_range(0, 2) == 0) r1 = ~r1;
      read_cycle(r0, r1, 9'($urandom), 9'($urandom), 1'b0, 1'b0);
    end
    read_cycle(r0, r1, 9'($urandom), 9'($urandom), 1'b1, 1'b0);
    check("frame_two", 32'(m_frame_cnt), 32'd2);

    // Asynchronous reset while port 0 holds a grant.
    ctl_cycle(1'b1, 1'b0, 10'd0, 0, 1'b0, 1'b0);
    ctl_cycle(1'b0, 1'b1, 10'd511, 1, 1'b1, 1'b0);
    flush_phase(1);
    read_cycle(1'b1, 1'b0, 9'h0F0, 9'h00F, 1'b0, 1'b0);
    #5;
    check("pre_rst_gnt0", 32'(m_gnt0), 32'd1);
    sys_rstn = 1'b0;
    #1;
    check("arst_gnt0",  32'(m_gnt0),      32'd0);
    check("arst_busy",  32'(m_busy),      32'd0);
    check("arst_state", 32'(m_state),     32'd0);
    check("arst_err",   32'(m_err),       32'd0);
    check("arst_frame", 32'(m_frame_cnt), 32'd0);
    tick();
    sys_rstn = 1'b1;
    model_reset();
    ctl_cycle(1'b0, 1'b0, 10'd0, 0, 1'b0, 1'b0);

    // Frame counter wraps after 256 frames.
    for (int f = 0; f < 256; f++) begin
      quick_frame();
    end
    check("frame_wrap", 32'(m_frame_cnt), 32'd0);
    ctl_cycle(1'b0, 1'b0, 10'd0, 0, 1'b0, 1'b0);

`ifdef FFT_SCHED_WATCHDOG_EN
    begin
      int n_cap;
      ctl_cycle(1'b1, 1'b0, 10'd0, 0, 1'b0, 1'b0);
      s_frame_start = 1'b0;
      s_req0        = 1'b0;
      s_req1        = 1'b0;
      s_read_done   = 1'b0;
      n_cap = 0;
      for (int c = 0; c < 70000; c++) begin
        #5;
        if (m_state != 2'd1) break;
        n_cap++;
        tick();
      end
      check("wd_cycles", 32'(n_cap),        32'd65535);
      check("wd_state",  32'(m_state),      32'd0);
      check("wd_err",    32'(m_err),        32'd1);
      check("wd_cap",    32'(m_capture_en), 32'd0);
      check("wd_frames", 32'(m_frame_cnt),  32'(exp_frames));
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
